// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix definitions: transfer/burst encodings,
// arbitration modes and burst length decode.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int BEAT_W = 4;

    // Remaining beats after the NONSEQ beat; undefined-length bursts hold nothing.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [BEAT_W-1:0] n;
        n = '0;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  n = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  n = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
            default:                      n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_mtx_prio_pick.sv
// Rotating priority encoder: first eligible index scanning upward
// from base, wrapping modulo N.
module ahb_mtx_prio_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] base,
    output logic [IW-1:0] grant,
    output logic          any
);

    always_comb begin
        int idx;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(base) + k;
            if (idx >= N) idx = idx - N;
            if (!any && eligible[idx]) begin
                any   = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_arb_param.sv
// AHB matrix output-stage arbiter: fixed or round-robin selection,
// grant held across locked sequences and fixed-length bursts.
module ahb_mtx_arb_param
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    parameter int ARB_MODE   = 0,
    parameter int BURST_HOLD = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    localparam logic [PORT_W-1:0] LAST = PORT_W'(NUM_PORTS - 1);

    logic [BEAT_W-1:0]    beats_left;
    logic [BEAT_W-1:0]    beats_nxt;
    logic [PORT_W-1:0]    rr_ptr;
    logic [PORT_W-1:0]    base;
    logic [PORT_W-1:0]    pick;
    logic                 pick_any;
    logic [NUM_PORTS-1:0] eligible;
    logic                 burst_hold;
    logic [PORT_W-1:0]    port_nxt;
    logic                 no_port_nxt;
    logic                 rr_load;

    // The current owner stays eligible while it is mid-transfer.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_port[i] |
                          ((addr_in_port == PORT_W'(i)) && HSELM &&
                           (HTRANSM != HTRANS_IDLE));
        end
    end

    always_comb begin
        beats_nxt = beats_left;
        if (!HSELM) begin
            beats_nxt = '0;
        end else begin
            case (HTRANSM)
                HTRANS_NONSEQ: beats_nxt = burst_beats(HBURSTM);
                HTRANS_SEQ:
                    if (beats_left != '0) beats_nxt = beats_left - 1'b1;
                HTRANS_IDLE:   beats_nxt = '0;
                default:       beats_nxt = beats_left;
            endcase
        end
    end

    assign burst_hold = (BURST_HOLD != 0) && (beats_nxt != '0);

    always_comb begin
        base = '0;
        if (ARB_MODE == ARB_RR) begin
            base = (rr_ptr == LAST) ? '0 : rr_ptr + PORT_W'(1);
        end
    end

    ahb_mtx_prio_pick #(
        .N  (NUM_PORTS),
        .IW (PORT_W)
    ) u_pick (
        .eligible (eligible),
        .base     (base),
        .grant    (pick),
        .any      (pick_any)
    );

    always_comb begin
        port_nxt    = addr_in_port;
        no_port_nxt = 1'b0;
        rr_load     = 1'b0;
        if (HMASTLOCKM) begin
            port_nxt = addr_in_port;
        end else if (burst_hold) begin
            port_nxt = addr_in_port;
        end else if (pick_any) begin
            port_nxt = pick;
            rr_load  = 1'b1;
        end else if (HSELM) begin
            port_nxt = addr_in_port;
        end else begin
            no_port_nxt = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            beats_left   <= '0;
            rr_ptr       <= LAST;
        end else if (HREADYM) begin
            addr_in_port <= port_nxt;
            no_port      <= no_port_nxt;
            beats_left   <= beats_nxt;
            if (rr_load) rr_ptr <= pick;
        end
    end

endmodule

// File: tb/tb_ahb_mtx_arb_param.sv
// Directed bench: three arbiter builds (fixed/hold, round-robin,
// fixed/no-hold) share stimulus; each vector selects which to check.
module tb_ahb_mtx_arb_param;
    import ahb_mtx_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic [3:0] req_port = '0;
    logic       HREADYM = 1'b1;
    logic       HSELM = 1'b0;
    logic [1:0] HTRANSM = HTRANS_IDLE;
    logic [2:0] HBURSTM = HBURST_SINGLE;
    logic       HMASTLOCKM = 1'b0;

    logic [1:0] p_fix, p_rr, p_nh;
    logic       n_fix, n_rr, n_nh;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_mtx_arb_param #(.NUM_PORTS(4), .ARB_MODE(ARB_FIXED), .BURST_HOLD(1)) u_fix (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(p_fix), .no_port(n_fix));

    ahb_mtx_arb_param #(.NUM_PORTS(4), .ARB_MODE(ARB_RR), .BURST_HOLD(1)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(p_rr), .no_port(n_rr));

    ahb_mtx_arb_param #(.NUM_PORTS(4), .ARB_MODE(ARB_FIXED), .BURST_HOLD(0)) u_nh (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(p_nh), .no_port(n_nh));

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       rdy;
        logic       sel;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       lock;
        logic [2:0] mask;
        logic [1:0] ep;
        logic       en;
    } vec_t;

    localparam logic [2:0] M_FIX = 3'b001;
    localparam logic [2:0] M_RR  = 3'b010;
    localparam logic [2:0] M_NH  = 3'b100;
    localparam logic [2:0] M_ALL = 3'b111;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [3:0] req, logic rdy, logic sel,
                                logic [1:0] trans, logic [2:0] burst, logic lock,
                                logic [2:0] mask, logic [1:0] ep, logic en);
        vec_t v;
        v.rst = rst; v.req = req; v.rdy = rdy; v.sel = sel;
        v.trans = trans; v.burst = burst; v.lock = lock;
        v.mask = mask; v.ep = ep; v.en = en;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [1:0] ap, input logic an,
                       input logic [1:0] ep, input logic en);
        checks++;
        if (ap !== ep || an !== en) begin
            failures++;
            $display("FAIL %s: addr_in_port=%0d no_port=%b, expected addr_in_port=%0d no_port=%b",
                     nm, ap, an, ep, en);
        end
    endtask

    task automatic check_mask(input string nm, input logic [2:0] m,
                              input logic [1:0] ep, input logic en);
        if (m[0]) chk({nm, "/fix"}, p_fix, n_fix, ep, en);
        if (m[1]) chk({nm, "/rr"},  p_rr,  n_rr,  ep, en);
        if (m[2]) chk({nm, "/nh"},  p_nh,  n_nh,  ep, en);
    endtask

    task automatic drive(input logic [3:0] req, input logic rdy, input logic sel,
                         input logic [1:0] trans, input logic [2:0] burst,
                         input logic lock);
        req_port = req; HREADYM = rdy; HSELM = sel;
        HTRANSM = trans; HBURSTM = burst; HMASTLOCKM = lock;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
        HRESETn = 1'b0;
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        #1;
        check_mask("reset", M_ALL, 2'd0, 1'b1);
    endtask

    task automatic apply(input string nm, input vec_t v);
        drive(v.req, v.rdy, v.sel, v.trans, v.burst, v.lock);
        @(posedge HCLK);
        #1;
        check_mask(nm, v.mask, v.ep, v.en);
    endtask

    initial begin
        // Basic fixed-priority grants and idle/no-port behaviour.
        tbl.push_back(mk(1, 4'b0000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_ALL, 2'd0, 1));
        tbl.push_back(mk(0, 4'b1010, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_ALL, 2'd1, 0));
        tbl.push_back(mk(0, 4'b1000, 1, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, M_ALL, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, M_ALL, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_ALL, 2'd3, 1));
        // Round-robin rotation with all ports requesting.
        tbl.push_back(mk(1, 4'b1111, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_RR,  2'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_RR,  2'd1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_RR,  2'd2, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_RR,  2'd3, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_RR,  2'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_FIX, 2'd0, 0));

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // INCR4 burst from port 2 while port 0 requests.
        do_reset();
        apply("burst_grant", mk(0, 4'b0100, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_FIX | M_NH, 2'd2, 0));
        apply("burst_ns",    mk(0, 4'b0001, 1, 1, HTRANS_NONSEQ, HBURST_INCR4,  0, M_FIX, 2'd2, 0));
        chk("burst_ns/nh", p_nh, n_nh, 2'd0, 1'b0);
        apply("burst_seq1",  mk(0, 4'b0001, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  0, M_FIX, 2'd2, 0));
        apply("burst_seq2",  mk(0, 4'b0001, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  0, M_FIX, 2'd2, 0));
        apply("burst_seq3",  mk(0, 4'b0001, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  0, M_FIX | M_NH, 2'd0, 0));

        // Early termination: IDLE mid INCR8 re-arbitrates on that beat.
        do_reset();
        apply("early_grant", mk(0, 4'b0100, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_FIX, 2'd2, 0));
        apply("early_ns",    mk(0, 4'b0001, 1, 1, HTRANS_NONSEQ, HBURST_INCR8,  0, M_FIX, 2'd2, 0));
        apply("early_seq",   mk(0, 4'b0001, 1, 1, HTRANS_SEQ,    HBURST_INCR8,  0, M_FIX, 2'd2, 0));
        apply("early_idle",  mk(0, 4'b0001, 1, 1, HTRANS_IDLE,   HBURST_INCR8,  0, M_FIX, 2'd0, 0));

        // Locked sequence on port 3, then wait states freezing the grant.
        do_reset();
        apply("lock_grant",  mk(0, 4'b1000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_FIX | M_NH, 2'd3, 0));
        for (int k = 0; k < 3; k++)
            apply($sformatf("lock_hold%0d", k),
                  mk(0, 4'b0001, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, M_FIX | M_NH, 2'd3, 0));
        apply("lock_drop",   mk(0, 4'b0001, 1, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, M_FIX | M_NH, 2'd0, 0));
        for (int k = 0; k < 4; k++)
            apply($sformatf("wait%0d", k),
                  mk(0, 4'b1000, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 0, M_ALL, 2'd0, 0));
        apply("wait_release", mk(0, 4'b1000, 1, 0, HTRANS_IDLE,  HBURST_SINGLE, 0, M_FIX | M_NH, 2'd3, 0));

        // Asynchronous reset during beat 2 of an INCR8 burst.
        do_reset();
        apply("rst_grant",   mk(0, 4'b0010, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_FIX, 2'd1, 0));
        apply("rst_ns",      mk(0, 4'b0001, 1, 1, HTRANS_NONSEQ, HBURST_INCR8,  0, M_FIX, 2'd1, 0));
        drive(4'b0001, 1'b1, 1'b1, HTRANS_SEQ, HBURST_INCR8, 1'b0);
        #3;
        HRESETn = 1'b0;
        #1;
        check_mask("rst_async", M_ALL, 2'd0, 1'b1);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        apply("rst_fresh",   mk(0, 4'b0100, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, M_FIX, 2'd2, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
